// File: rtl/fifo_rd_packer.sv
// Packs a byte stream from a 1-cycle-latency FIFO read port into NB-byte
// little-endian words, with a flush that emits any partially packed word.
module fifo_rd_packer #(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            o_fifo_empty,
  output logic            rd_en,
  input  logic [7:0]      rd_data,
  input  logic            flush,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [8*NB-1:0] m_data,
  output logic [NB-1:0]   m_keep,
  output logic            m_last
);

  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [CW:0]   OCC_LIM  = (CW + 1)'(NB - 1);

  typedef enum logic {FILL, FLUSH_WAIT} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            inflight;
  logic [8*NB-1:0] acc;
  logic [8*NB-1:0] acc_with_byte;
  logic [CW:0]     occ;
  logic            out_free;
  logic            flush_done;
  logic [NB-1:0]   partial_keep;

  // Reads are throttled so that a byte completing a word always finds the
  // output register free on the edge it arrives.
  always_comb begin
    state_next    = state;
    rd_en         = 1'b0;
    flush_done    = 1'b0;
    occ           = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    out_free      = !m_valid || m_ready;
    acc_with_byte = acc;
    acc_with_byte[{cnt, 3'b000} +: 8] = rd_data;
    partial_keep  = (NB'(1) << cnt) - NB'(1);
    case (state)
      FILL: begin
        rd_en = !o_fifo_empty && !rst && ((occ < OCC_LIM) || out_free);
        if (flush) state_next = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (!inflight && out_free) begin
          flush_done = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Unused upper accumulator bytes stay zero, so a partial word needs no masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      inflight <= 1'b0;
      acc      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= rd_en;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (inflight) begin
        if (cnt == CNT_LAST) begin
          m_data  <= acc_with_byte;
          m_keep  <= '1;
          m_last  <= 1'b0;
          m_valid <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc_with_byte;
          cnt <= cnt + CW'(1);
        end
      end else if (flush_done && cnt != '0) begin
        m_data  <= acc;
        m_keep  <= partial_keep;
        m_last  <= 1'b1;
        m_valid <= 1'b1;
        acc     <= '0;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter: NB, default 4, bytes per output word (legal 2..8).
REQ-002 SHALL have port: clk  input  1  single clock, also the FIFO read-side clock (rd_clk).
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: o_fifo_empty  input  1  FIFO empty flag, read domain.
REQ-005 SHALL have port: rd_en  output  1  FIFO read request.
REQ-006 SHALL have port: rd_data  input  8  FIFO read data.
REQ-007 SHALL have port: flush  input  1  request to emit partially packed word.
REQ-008 SHALL have port: m_valid  output  1  output word valid.
REQ-009 SHALL have port: m_ready  input  1  downstream accept.
REQ-010 SHALL have port: m_data  output  8*NB  packed word.
REQ-011 SHALL have port: m_keep  output  NB  byte-valid mask.
REQ-012 SHALL have port: m_last  output  1  word produced by flush.

Function
REQ-013 SHALL treat the FIFO read as 1-cycle latency: rd_en=1 with o_fifo_empty=0 in cycle t delivers a valid byte on rd_data in cycle t+1 (inflight flag).
REQ-014 SHALL drive rd_en combinationally: 1 only when o_fifo_empty=0, rst=0, state=FILL, and (occ < NB-1 or m_valid=0 or m_ready=1); occ = cnt + inflight.
REQ-015 SHALL pack bytes little-endian: first captured byte in m_data[7:0], k-th byte in m_data[8k+7:8k].
REQ-016 SHALL keep byte count cnt in range 0..NB-1 in the accumulator; the NB-th captured byte moves the full word into the output register in that same edge, cnt -> 0.
REQ-017 SHALL present full words with m_keep=all ones, m_last=0.
REQ-018 SHALL hold m_data/m_keep/m_last stable while m_valid=1 and m_ready=0; transfer occurs on a cycle with m_valid=1 and m_ready=1.
REQ-019 SHALL sustain one word per NB cycles when the FIFO is non-empty and m_ready=1 continuously.
REQ-020 SHALL implement state machine FILL -> FLUSH_WAIT on flush=1 in FILL; flush in FLUSH_WAIT is ignored.
REQ-021 SHALL, in FLUSH_WAIT, hold rd_en=0, capture any inflight byte, and wait until inflight=0 and output register free (m_valid=0, or m_ready=1 this cycle).
REQ-022 SHALL, on leaving FLUSH_WAIT with cnt>0, load output register with accumulator, m_keep low cnt bits set, unused m_data bytes 0, m_last=1, cnt -> 0; return to FILL.
REQ-023 SHALL, on leaving FLUSH_WAIT with cnt=0, emit nothing and return to FILL.
REQ-024 SHALL, when flush arrives in the same cycle the NB-th byte is captured, move that full word (m_last=0) and flush with cnt=0 (no partial word).
REQ-025 SHALL never drop, duplicate, or reorder bytes under any m_ready pattern or o_fifo_empty toggling.

Reset
REQ-026 SHALL, with rst=1 at a clk edge, set m_valid=0, m_data=0, m_keep=0, m_last=0, cnt=0, inflight=0, state=FILL; rd_en=0 while rst=1.
REQ-027 SHALL discard a byte inflight when rst is asserted (mid-operation reset loses accumulator and pending word).

Verification
REQ-028 SHALL cover: FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 -> one word m_data=0x44332211, m_keep=0xF, m_last=0, within 6 cycles of first rd_en.
REQ-029 SHALL cover: 8 bytes 0x01..0x08, m_ready=0 for 10 cycles then 1 -> rd_en stalls after 7 reads; words 0x04030201 then 0x08070605, no loss.
REQ-030 SHALL cover: 3 bytes 0xAA,0xBB,0xCC then flush pulse -> m_data=0x00CCBBAA, m_keep=0x7, m_last=1; rd_en=0 during FLUSH_WAIT.
REQ-031 SHALL cover: flush with cnt=0 and nothing inflight -> no m_valid, state returns to FILL next cycle.
REQ-032 SHALL cover: rst asserted one cycle after rd_en with 2 bytes accumulated -> all outputs 0 next cycle; next 4 bytes form a fresh word.
REQ-033 SHALL cover: random o_fifo_empty and m_ready, 1000 bytes -> scoreboard output bytes equal input sequence.
